lcd_controller: RTL and testbench
=================================

Name: lcd_controller

Overview:
- Memory-mapped HD44780-style LCD sequencer placed between the CPU data bus and the lcd_data/lcd_ctrl/lcd_enable pins.
- Replaces software bit-banging of the enable strobe. The CPU writes data bytes or instruction bytes into a small command FIFO.
- The block drains the FIFO and generates setup, enable-pulse, hold and execution-wait timing per entry.
- Exposes a status word for polling.

Parameters:
- FIFO_DEPTH, 8, command FIFO entries; power of two, >=2.
- SETUP_CYCLES, 2, cycles lcd_data/lcd_ctrl are stable before lcd_enable rises; >=1.
- EN_HIGH_CYCLES, 4, cycles lcd_enable is held high; >=1.
- HOLD_CYCLES, 2, cycles data is held after lcd_enable falls; >=1.
- CMD_WAIT, 40, execution-wait cycles after a normal entry; >=1.
- LONG_WAIT, 1600, execution-wait cycles after instruction 0x01, 0x02 or 0x03 (clear/home); >=1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- bus_wenable  input  1  write strobe from the bus decoder; one write per high cycle.
- bus_addr  input  2  register select.
- bus_wdata  input  32  write data; only [7:0] is used.
- bus_rdata  output  32  combinational read of the register selected by bus_addr.
- lcd_data  output  8  LCD data bus.
- lcd_ctrl  output  2  {RS, RW}: 2'b10 = data write, 2'b00 = instruction write; RW is always 0.
- lcd_enable  output  1  LCD E strobe.

Behaviour:
- Reset: synchronous, active-high.
  - All of the following clear on the first rising clk edge with rst=1: lcd_data=0, lcd_ctrl=0, lcd_enable=0, FIFO empty, overflow=0, FSM=IDLE, counter=0.
  - Reset mid-transfer drops lcd_enable immediately (next edge) and discards the in-flight entry and all FIFO contents.
- Register map (written when bus_wenable=1):
  - addr 0: push {RS=1, wdata[7:0]}, a data byte.
  - addr 1: push {RS=0, wdata[7:0]}, an instruction byte.
  - addr 2: status, read-only; writes are ignored.
  - addr 3: write of any value clears overflow.
- Status read (addr 2): bus_rdata = {zeros, level[log2(FIFO_DEPTH):0] at [8+:], overflow at [3], full at [2], empty at [1], busy at [0]}. Reads of addr 0/1/3 return 0.
- busy = (FSM != IDLE) or !empty.
- Push while full: the write is dropped, overflow is set (sticky), and FIFO contents are unchanged.
  - The full flag is the registered value, so a push in the same cycle as a pop while full is still dropped.
- FSM states: IDLE -> SETUP -> PULSE -> HOLD -> WAIT -> IDLE.
  - IDLE: if FIFO not empty, pop on this edge, load lcd_data=byte and lcd_ctrl={RS,0}, load counter=SETUP_CYCLES-1, go SETUP. Otherwise stay.
  - SETUP: lcd_enable=0. When counter=0: set lcd_enable=1, counter=EN_HIGH_CYCLES-1, go PULSE. Else decrement.
  - PULSE: lcd_enable=1. When counter=0: clear lcd_enable, counter=HOLD_CYCLES-1, go HOLD.
  - HOLD: lcd_data/lcd_ctrl unchanged. When counter=0, go WAIT with counter=(long ? LONG_WAIT : CMD_WAIT)-1.
    - long = RS=0 and byte in {0x01,0x02,0x03}.
  - WAIT: when counter=0, go IDLE.
- Timing guarantees:
  - lcd_data/lcd_ctrl change only on the IDLE->SETUP edge.
  - lcd_enable is high for exactly EN_HIGH_CYCLES cycles per entry.
  - Entry start-to-start spacing (back-to-back, FIFO non-empty) = 1 + SETUP_CYCLES + EN_HIGH_CYCLES + HOLD_CYCLES + wait.
- Latency: a push at edge E0 into an empty FIFO with the FSM in IDLE gives lcd_data valid after E1, and lcd_enable rises after edge E1+SETUP_CYCLES.
- Counter width: clog2(max(all timing params)) bits. Pointers wrap modulo FIFO_DEPTH. Level is kept in log2(FIFO_DEPTH)+1 bits so the full state is representable.

Decomposition:
- Shared header lcd_defs.vh holds:
  - register addresses (LCD_REG_DATA=0, LCD_REG_CMD=1, LCD_REG_STATUS=2, LCD_REG_CLR=3);
  - lcd_ctrl encodings (LCD_CTRL_DATA=2'b10, LCD_CTRL_CMD=2'b00);
  - FSM state encodings;
  - status bit positions.
- One sub-module, sync_fifo: parameterised width (9) and depth; push/pop/full/empty/level; synchronous active-high reset.
- Bus decode, FSM and timing counter stay in lcd_controller.

Test Plan:
- Reset: assert rst for 2 cycles mid-PULSE -> lcd_enable=0 after the next edge; status reads 0x002 (empty=1, all else 0); lcd_data=0.
- Single data write 0x41 to addr 0 -> lcd_data=0x41, lcd_ctrl=2'b10 one edge later. lcd_enable rises 2 cycles after that and stays high exactly 4 cycles. busy returns to 0 after 1+2+4+2+40 cycles.
- Instruction 0x01 to addr 1 -> lcd_ctrl=2'b00, WAIT lasts 1600 cycles. Instruction 0x38 -> WAIT lasts 40 cycles.
- Burst of 8 data writes "HELLO123" on consecutive cycles -> full=1 and level=8 on the status read (cycle after the 8th write, before the first pop has taken effect). Bytes appear on lcd_data in order, each with one enable pulse. Falling-edge capture yields "HELLO123".
- Ninth write while full (0x5A) -> dropped, overflow=1, never appears on lcd_data. Write to addr 3 -> overflow=0.
- Write to addr 2 while FIFO is empty -> no push, status unchanged, lcd_enable stays 0.

Source files
------------

// File: rtl/lcd_controller_pkg.sv
// Shared definitions for the LCD sequencer: register map, lcd_ctrl encodings,
// FSM state codes and status word bit positions.
package lcd_controller_pkg;

    localparam logic [1:0] LCD_REG_DATA   = 2'd0;
    localparam logic [1:0] LCD_REG_CMD    = 2'd1;
    localparam logic [1:0] LCD_REG_STATUS = 2'd2;
    localparam logic [1:0] LCD_REG_CLR    = 2'd3;

    localparam logic [1:0] LCD_CTRL_DATA  = 2'b10;
    localparam logic [1:0] LCD_CTRL_CMD   = 2'b00;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SETUP = 3'd1;
    localparam logic [2:0] ST_PULSE = 3'd2;
    localparam logic [2:0] ST_HOLD  = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_EMPTY     = 1;
    localparam int STAT_FULL      = 2;
    localparam int STAT_OVERFLOW  = 3;
    localparam int STAT_LEVEL_LSB = 8;

    // Clear display / return home instructions need the long execution wait.
    function automatic logic is_long_cmd(input logic [1:0] ctrl, input logic [7:0] b);
        return (ctrl == LCD_CTRL_CMD) && (b == 8'h01 || b == 8'h02 || b == 8'h03);
    endfunction

endpackage

// File: rtl/lcd_controller_sync_fifo.sv
// Synchronous show-ahead FIFO with occupancy level; pushes while full and
// pops while empty are ignored.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/lcd_controller.sv
// Memory-mapped HD44780-style LCD sequencer: queues bus writes and replays them
// on the LCD pins with setup, enable pulse, hold and execution-wait timing.
module lcd_controller
    import lcd_controller_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int SETUP_CYCLES   = 2,
    parameter int EN_HIGH_CYCLES = 4,
    parameter int HOLD_CYCLES    = 2,
    parameter int CMD_WAIT       = 40,
    parameter int LONG_WAIT      = 1600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_wenable,
    input  logic [1:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic [7:0]  lcd_data,
    output logic [1:0]  lcd_ctrl,
    output logic        lcd_enable
);

    localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int MAX_T0 = (SETUP_CYCLES > EN_HIGH_CYCLES) ? SETUP_CYCLES : EN_HIGH_CYCLES;
    localparam int MAX_T1 = (MAX_T0 > HOLD_CYCLES) ? MAX_T0 : HOLD_CYCLES;
    localparam int MAX_T2 = (MAX_T1 > CMD_WAIT) ? MAX_T1 : CMD_WAIT;
    localparam int MAX_T  = (MAX_T2 > LONG_WAIT) ? MAX_T2 : LONG_WAIT;
    localparam int CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(EN_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LOAD   = CNT_W'(CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] LONG_LOAD  = CNT_W'(LONG_WAIT - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             overflow;

    logic             wr_data;
    logic             wr_cmd;
    logic             wr_clr;
    logic             fifo_push;
    logic             fifo_pop;
    logic [8:0]       fifo_wdata;
    logic [8:0]       fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic             busy;
    logic [31:0]      status;
    logic             unused_wdata;

    assign wr_data      = bus_wenable && (bus_addr == LCD_REG_DATA);
    assign wr_cmd       = bus_wenable && (bus_addr == LCD_REG_CMD);
    assign wr_clr       = bus_wenable && (bus_addr == LCD_REG_CLR);
    assign fifo_push    = wr_data || wr_cmd;
    assign fifo_wdata   = {wr_data, bus_wdata[7:0]};
    assign fifo_pop     = (state == ST_IDLE) && !fifo_empty;
    assign unused_wdata = ^bus_wdata[31:8];

    sync_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    assign busy = (state != ST_IDLE) || !fifo_empty;

    always_comb begin
        status                               = '0;
        status[STAT_LEVEL_LSB +: LVL_W]      = fifo_level;
        status[STAT_OVERFLOW]                = overflow;
        status[STAT_FULL]                    = fifo_full;
        status[STAT_EMPTY]                   = fifo_empty;
        status[STAT_BUSY]                    = busy;
    end

    assign bus_rdata = (bus_addr == LCD_REG_STATUS) ? status : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            lcd_data   <= '0;
            lcd_ctrl   <= '0;
            lcd_enable <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            // fifo_full is the pre-edge value, so a push racing a pop while full is lost.
            if (fifo_push && fifo_full) begin
                overflow <= 1'b1;
            end else if (wr_clr) begin
                overflow <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        lcd_data <= fifo_rdata[7:0];
                        lcd_ctrl <= fifo_rdata[8] ? LCD_CTRL_DATA : LCD_CTRL_CMD;
                        cnt      <= SETUP_LOAD;
                        state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt == '0) begin
                        lcd_enable <= 1'b1;
                        cnt        <= PULSE_LOAD;
                        state      <= ST_PULSE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (cnt == '0) begin
                        lcd_enable <= 1'b0;
                        cnt        <= HOLD_LOAD;
                        state      <= ST_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    // lcd_data/lcd_ctrl still hold the entry, so they decide the wait length.
                    if (cnt == '0) begin
                        cnt   <= is_long_cmd(lcd_ctrl, lcd_data) ? LONG_LOAD : CMD_LOAD;
                        state <= ST_WAIT;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_controller.sv
// Directed bench for lcd_controller: bus writes push expected LCD entries into
// a queue, and a falling-enable monitor pops and compares them.
module tb_lcd_controller;

    localparam int EN_HIGH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_wenable;
    logic [1:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic [7:0]  lcd_data;
    logic [1:0]  lcd_ctrl;
    logic        lcd_enable;

    int vectors     = 0;
    int miscompares = 0;

    logic [9:0]  exp_q[$];
    logic [63:0] cap_buf;

    lcd_controller dut (
        .clk         (clk),
        .rst         (rst),
        .bus_wenable (bus_wenable),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .lcd_data    (lcd_data),
        .lcd_ctrl    (lcd_ctrl),
        .lcd_enable  (lcd_enable)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d, input bit accept);
        @(negedge clk);
        bus_addr    = a;
        bus_wdata   = {24'hA5A5A5, d};
        bus_wenable = 1'b1;
        if (accept && a <= 2'd1) begin
            exp_q.push_back({(a == 2'd0), 1'b0, d});
        end
        @(posedge clk);
        #1;
        bus_wenable = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
        bus_addr = a;
        #1;
        v = bus_rdata;
    endtask

    // Counts edges until busy drops; n starts at the edges already elapsed.
    task automatic wait_idle(output int n, input int start, input int limit);
        logic [31:0] st;
        n = start;
        do begin
            @(posedge clk);
            #1;
            n++;
            read_reg(2'd2, st);
        end while (st[0] && n < limit);
    endtask

    // Falling-enable monitor: checks pulse width, stability and entry order.
    logic       prev_en = 1'b0;
    int         hi_cnt  = 0;
    logic [9:0] rise_val;
    always @(negedge clk) begin
        if (rst) begin
            prev_en = 1'b0;
            hi_cnt  = 0;
        end else begin
            if (lcd_enable) begin
                if (!prev_en) begin
                    rise_val = {lcd_ctrl, lcd_data};
                end
                hi_cnt++;
            end else if (prev_en) begin
                check("pulse_width", hi_cnt, EN_HIGH);
                check("pulse_stable", {lcd_ctrl, lcd_data}, rise_val);
                check("queue_nonempty", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    check("lcd_entry", {lcd_ctrl, lcd_data}, exp_q.pop_front());
                end
                if (lcd_ctrl == 2'b10) begin
                    cap_buf = {cap_buf[55:0], lcd_data};
                end
                hi_cnt = 0;
            end
            prev_en = lcd_enable;
        end
    end

    initial begin
        logic [31:0] st;
        logic [7:0]  msg [8];
        logic [63:0] cap_exp;
        int          n;
        bit          saw_en;

        msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F, 8'h31, 8'h32, 8'h33};
        cap_exp = "HELLO123";

        rst = 1'b1;
        bus_wenable = 1'b0;
        bus_addr = 2'd0;
        bus_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_enable", lcd_enable, 0);
        check("reset_data", lcd_data, 0);
        check("reset_ctrl", lcd_ctrl, 0);
        read_reg(2'd2, st);
        check("reset_status", st, 32'h002);
        @(negedge clk);
        rst = 1'b0;
        read_reg(2'd0, st);
        check("read_addr0_zero", st, 0);

        // Single data byte: latency, enable rise and total busy time.
        bus_write(2'd0, 8'h41, 1);
        check("data_before_e1", lcd_data, 0);
        @(posedge clk); #1;
        check("data_e1", lcd_data, 8'h41);
        check("ctrl_e1", lcd_ctrl, 2'b10);
        check("en_e1", lcd_enable, 0);
        @(posedge clk); #1;
        check("en_e2", lcd_enable, 0);
        @(posedge clk); #1;
        check("en_e3", lcd_enable, 1);
        wait_idle(n, 3, 3000);
        check("busy_cycles_data", n, 49);

        // Clear instruction takes the long wait; 0x38 the normal one.
        bus_write(2'd1, 8'h01, 1);
        @(posedge clk); #1;
        check("ctrl_cmd01", lcd_ctrl, 2'b00);
        check("data_cmd01", lcd_data, 8'h01);
        wait_idle(n, 1, 3000);
        check("busy_cycles_cmd01", n, 1609);

        bus_write(2'd1, 8'h38, 1);
        @(posedge clk); #1;
        check("ctrl_cmd38", lcd_ctrl, 2'b00);
        wait_idle(n, 1, 3000);
        check("busy_cycles_cmd38", n, 49);

        // Burst of 8 while the FSM is busy with an instruction fills the FIFO.
        bus_write(2'd1, 8'h38, 1);
        cap_buf = '0;
        for (int i = 0; i < 8; i++) begin
            bus_write(2'd0, msg[i], 1);
        end
        read_reg(2'd2, st);
        check("status_full", st, 32'h805);
        bus_write(2'd0, 8'h5A, 0);
        read_reg(2'd2, st);
        check("status_overflow", st, 32'h80D);
        bus_write(2'd3, 8'h00, 0);
        read_reg(2'd2, st);
        check("status_ovf_clear", st, 32'h805);
        wait_idle(n, 10, 6000);
        check("busy_cycles_burst", n, 441);
        check("capture_hello", cap_buf[63:32], cap_exp[63:32]);
        check("capture_123", cap_buf[31:0], cap_exp[31:0]);
        check("queue_drained", exp_q.size(), 0);

        // Write to the status address must not push anything.
        bus_write(2'd2, 8'hFF, 0);
        read_reg(2'd2, st);
        check("status_after_addr2_write", st, 32'h002);
        saw_en = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            if (lcd_enable) saw_en = 1'b1;
        end
        check("no_pulse_addr2", saw_en, 0);

        // Reset in the middle of the enable pulse.
        bus_write(2'd0, 8'h77, 1);
        n = 0;
        while (!lcd_enable && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("reach_pulse", lcd_enable, 1);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("reset_drops_enable", lcd_enable, 0);
        @(posedge clk); #1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        read_reg(2'd2, st);
        check("reset_mid_status", st, 32'h002);
        check("reset_mid_data", lcd_data, 0);
        check("reset_mid_ctrl", lcd_ctrl, 0);

        // Normal operation resumes after reset.
        bus_write(2'd0, 8'h55, 1);
        wait_idle(n, 0, 3000);
        check("busy_cycles_after_reset", n, 49);
        check("queue_final", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
